// File: rtl/vending_pkg.sv
// vending_pkg: definitions shared by the dispense arbiter and the vending FSM.
//   arb_state_e  : arbiter FSM state encoding
//   DRINK_*      : drink codes carried on drink_sel / drink_out
//   TIMER_W      : width of the phase timer
package vending_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StGrant    = 2'd1,
        StDispense = 2'd2,
        StCooldown = 2'd3
    } arb_state_e;

    localparam logic DRINK_COFFEE = 1'b0;
    localparam logic DRINK_TEA    = 1'b1;

    localparam int unsigned TIMER_W = 5;

endpackage

// File: rtl/dispense_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req         : request vector
//   last_served : index of the most recently served requester
//   valid       : at least one request is pending
//   winner      : first requesting index after last_served, wrapping
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_served,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    int unsigned cand;

    // Walk offsets 1..NUM_REQ from last_served; the first hit wins, so
    // last_served itself is considered only when nobody else is asking.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = 32'(last_served) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dispense_arbiter.sv
// dispense_arbiter: shares one drink dispenser between NUM_REQ requesters.
//   clk, rst   : clock and asynchronous active-high reset
//   req        : per-requester level request
//   drink_sel  : per-requester drink choice, sampled at arbitration
//   grant      : one-hot owner (GRANT and DISPENSE states)
//   dispense   : dispenser drive, DISPENSE_CYCLES clocks per service
//   drink_out  : drink latched for the current owner
//   done       : one-cycle completion pulse to the served requester
//   busy       : FSM not idle
//   timer      : phase counter in DISPENSE/COOLDOWN, else 0
module dispense_arbiter
    import vending_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned DISPENSE_CYCLES = 16,
    parameter int unsigned COOLDOWN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] drink_sel,
    output logic [NUM_REQ-1:0] grant,
    output logic               dispense,
    output logic               drink_out,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic [TIMER_W-1:0] timer
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TIMER_W-1:0] DISP_LAST = TIMER_W'(DISPENSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] COOL_LAST = TIMER_W'(COOLDOWN_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               drink_q, drink_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] owner_oh;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_served(last_q),
        .valid      (pick_valid),
        .winner     (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            winner_q <= '0;
            last_q   <= LAST_RST;
            drink_q  <= DRINK_COFFEE;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            drink_q  <= drink_d;
        end
    end

    // timer_d defaults to 0 so every state change restarts the count.
    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        winner_d = winner_q;
        last_d   = last_q;
        drink_d  = drink_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    winner_d = pick_idx;
                    drink_d  = drink_sel[pick_idx];
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                // A requester that gave up before service leaves the pointer alone.
                if (req[winner_q]) begin
                    state_d = StDispense;
                    last_d  = winner_q;
                end else begin
                    state_d = StIdle;
                end
            end
            StDispense: begin
                if (timer_q == DISP_LAST) begin
                    state_d = StCooldown;
                end else begin
                    timer_d = timer_q + 5'd1;
                end
            end
            StCooldown: begin
                if (timer_q == COOL_LAST) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 5'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_q;

    // Outputs decode registered state only, so reset clears them at once.
    always_comb begin
        grant    = '0;
        dispense = 1'b0;
        done     = '0;
        unique case (state_q)
            StGrant: grant = owner_oh;
            StDispense: begin
                grant    = owner_oh;
                dispense = 1'b1;
            end
            StCooldown: begin
                if (timer_q == '0) begin
                    done = owner_oh;
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign timer     = timer_q;
    assign drink_out = drink_q;

endmodule

// File: tb/tb_dispense_arbiter.sv
module tb_dispense_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] drink_sel;
    logic [3:0] grant;
    logic       dispense;
    logic       drink_out;
    logic [3:0] done;
    logic       busy;
    logic [4:0] timer;

    int checks   = 0;
    int failures = 0;

    // {grant, dispense, done, busy, timer}
    logic [14:0] obs;
    logic [14:0] exp_v;
    assign obs = {grant, dispense, done, busy, timer};

    always #5 clk = ~clk;

    dispense_arbiter #(
        .NUM_REQ        (4),
        .DISPENSE_CYCLES(16),
        .COOLDOWN_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .drink_sel(drink_sel),
        .grant    (grant),
        .dispense (dispense),
        .drink_out(drink_out),
        .done     (done),
        .busy     (busy),
        .timer    (timer)
    );

    // Expected outputs at cycle c for one service whose GRANT cycle is s.
    function automatic logic [14:0] svc(int c, int s, int idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        if (c == s)                  return {oh, 1'b0, 4'b0000, 1'b1, 5'd0};
        if (c > s && c <= s + 16)    return {oh, 1'b1, 4'b0000, 1'b1, 5'(c - s - 1)};
        if (c == s + 17)             return {4'b0000, 1'b0, oh, 1'b1, 5'd0};
        if (c == s + 18)             return {4'b0000, 1'b0, 4'b0000, 1'b1, 5'd1};
        return 15'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a posedge with rst low: cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        drink_sel = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        drink_sel = 4'b1111;
        repeat (3) step();
        checks++;
        if (obs !== 15'd0 || drink_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%h drink=%b required=%h drink=0", obs, drink_out, 15'd0);
        end
        rst = 1'b0;
        step();
        exp_v = svc(1, 1, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_first_priority got=%h required=%h", obs, exp_v);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        drink_sel = 4'b0001;
        for (int c = 1; c <= 21; c++) begin
            step();
            exp_v = svc(c, 1, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL single c=%0d got=%h required=%h", c, obs, exp_v);
            end
            if (c <= 17) begin
                checks++;
                if (drink_out !== 1'b1) begin
                    failures++;
                    $display("FAIL single_drink c=%0d got=%b required=1", c, drink_out);
                end
            end
            if (c == 18) req = 4'b0000;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 4'b1010;
        drink_sel = 4'b1000;
        for (int c = 1; c <= 41; c++) begin
            step();
            exp_v = svc(c, 1, 1) | svc(c, 21, 3);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL simultaneous c=%0d got=%h required=%h", c, obs, exp_v);
            end
            if ((c >= 2 && c <= 17) || (c >= 22 && c <= 37)) begin
                checks++;
                if (drink_out !== (c >= 22)) begin
                    failures++;
                    $display("FAIL simultaneous_drink c=%0d got=%b required=%b",
                             c, drink_out, (c >= 22));
                end
            end
            if (c == 18) req[1] = 1'b0;
            if (c == 38) req[3] = 1'b0;
        end
    endtask

    task automatic test_fairness();
        int order[4];
        int n;
        n = 0;
        do_reset();
        req = 4'b1111;
        drink_sel = 4'b0000;
        for (int c = 1; c <= 81; c++) begin
            step();
            exp_v = svc(c, 1, 0) | svc(c, 21, 1) | svc(c, 41, 2) | svc(c, 61, 3);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL fairness c=%0d got=%h required=%h", c, obs, exp_v);
            end
            if (grant != 4'b0000 && !dispense) begin
                for (int i = 0; i < 4; i++) begin
                    if (grant[i] && n < 4) order[n] = i;
                end
                n++;
            end
            for (int k = 0; k < 4; k++) begin
                if (c == 1 + 20 * k + 17) req[k] = 1'b0;
            end
        end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL fairness_grant_count got=%0d required=4", n);
        end
        for (int k = 0; k < 4 && k < n; k++) begin
            checks++;
            if (order[k] !== k) begin
                failures++;
                $display("FAIL fairness_order slot=%0d got=%0d required=%0d", k, order[k], k);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0100;
        drink_sel = 4'b0000;
        step();
        exp_v = svc(1, 1, 2);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL abort_grant got=%h required=%h", obs, exp_v);
        end
        req = 4'b0000;
        for (int c = 2; c <= 3; c++) begin
            step();
            checks++;
            if (obs !== 15'd0) begin
                failures++;
                $display("FAIL abort_idle c=%0d got=%h required=%h", c, obs, 15'd0);
            end
        end
        // Unchanged pointer picks index 2; a wrongly advanced one would pick 3.
        req = 4'b1100;
        step();
        exp_v = svc(4, 4, 2);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL abort_pointer got=%h required=%h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req = 4'b0001;
        drink_sel = 4'b0001;
        repeat (9) step();
        exp_v = svc(9, 1, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL midrst_pre got=%h required=%h", obs, exp_v);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 15'd0 || drink_out !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async got=%h drink=%b required=%h drink=0",
                     obs, drink_out, 15'd0);
        end
        step();
        checks++;
        if (obs !== 15'd0) begin
            failures++;
            $display("FAIL midrst_hold got=%h required=%h", obs, 15'd0);
        end
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            exp_v = svc(c, 1, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL midrst_reserve c=%0d got=%h required=%h", c, obs, exp_v);
            end
            if (c == 18) req = 4'b0000;
        end
    endtask

    task automatic test_request_while_busy();
        do_reset();
        req = 4'b0001;
        drink_sel = 4'b0010;
        for (int c = 1; c <= 40; c++) begin
            step();
            exp_v = svc(c, 1, 0) | svc(c, 21, 1);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL busy_req c=%0d got=%h required=%h", c, obs, exp_v);
            end
            if (c == 5) req[1] = 1'b1;
            if (c == 18) req[0] = 1'b0;
            if (c == 38) req[1] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        drink_sel = 4'b0000;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_abort();
        test_reset_mid_op();
        test_request_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dispense_arbiter.md
DISPENSE_ARBITER -- requirements
Module: dispense_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of front-panel requesters sharing one dispenser (2..8).
REQ-002 Parameter DISPENSE_CYCLES, default 16: dispense pulse length in clocks (1..31).
REQ-003 Parameter COOLDOWN_CYCLES, default 2: idle gap after each dispense (1..31).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester service request, level; held until that requester's done pulse or voluntarily dropped.
REQ-007 drink_sel  input  NUM_REQ  per-requester drink select (0 = coffee, 1 = tea), sampled at arbitration.
REQ-008 grant  output  NUM_REQ  one-hot owner of the dispenser, all-zero when unowned.
REQ-009 dispense  output  1  drive to dispenser mechanism.
REQ-010 drink_out  output  1  latched drink of current owner.
REQ-011 done  output  NUM_REQ  one-cycle completion pulse to the served requester.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 timer  output  5  current phase counter (DISPENSE or COOLDOWN), else 0.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, DISPENSE, COOLDOWN; all outputs registered or decoded from registered state only.
REQ-015 IDLE: if any req bit high, pick winner round-robin, latch winner index and drink_sel[winner], go to GRANT next edge; else stay.
REQ-016 Round-robin: search starts at index (last_served+1) mod NUM_REQ; pointer = NUM_REQ-1 after reset so index 0 has first priority.
REQ-017 GRANT (1 cycle): grant = one-hot winner; if req[winner] low, return to IDLE with no done and no pointer update; else go to DISPENSE and set last_served = winner.
REQ-018 DISPENSE: dispense=1, grant held, timer counts 0..DISPENSE_CYCLES-1; at DISPENSE_CYCLES-1 go to COOLDOWN; req changes ignored.
REQ-019 COOLDOWN: grant=0, dispense=0, done[winner]=1 in first COOLDOWN cycle only; timer counts 0..COOLDOWN_CYCLES-1 then IDLE.
REQ-020 Latency from req seen in IDLE at edge N: grant at N+1, dispense N+2..N+1+DISPENSE_CYCLES, done at next cycle.
REQ-021 Requests arriving while busy SHALL wait; none are lost while held; no requester is served twice while another waits.
REQ-022 timer SHALL never wrap; it resets to 0 on every state change.
REQ-023 grant, dispense, done SHALL never be asserted in the same cycle in conflicting combinations (dispense implies exactly one grant bit; done implies dispense=0).

Reset
REQ-024 On rst: state IDLE, grant=0, dispense=0, drink_out=0, done=0, busy=0, timer=0, last_served=NUM_REQ-1.
REQ-025 Reset mid-DISPENSE SHALL drop dispense immediately (asynchronously) and emit no done.

Structure
REQ-026 Package vending_pkg SHALL hold state encoding constants and drink codes (DRINK_COFFEE=0, DRINK_TEA=1), shared with the vending FSM.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, last_served; outputs valid, winner index).

Verification
REQ-028 Single: after reset, req=0001, drink_sel=0001 at cycle 0 -> grant=0001 cycle 1, dispense cycles 2-17, drink_out=1, done=0001 cycle 18, busy low cycle 20.
REQ-029 Simultaneous: req=1010 from reset -> index 1 served first, then index 3 granted cycle 21, done[3] at cycle 38.
REQ-030 Fairness: req=1111 held, each dropped after its done -> grant order 0,1,2,3, each exactly once.
REQ-031 Abort: req[2] pulsed only for the IDLE sample cycle -> grant=0100 one cycle, no dispense, no done, next arbitration still starts at index 0.
REQ-032 Reset mid-op: assert rst at dispense cycle 8 -> dispense/grant 0 immediately, no done; after release, req=0001 re-served from index 0.
REQ-033 Request during busy: req[1] raised during index 0 DISPENSE -> grant=0010 the cycle after COOLDOWN ends +1.
